// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: edge-qualifies rx_done, filters frames by error policy,
// buffers them in a first-word-fall-through FIFO and keeps saturating error statistics.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter bit          DROP_ERR = 1'b0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_en,
  input  logic                     flush,
  input  logic [7:0]               rx_data,
  input  logic                     rx_parity_err,
  input  logic                     rx_stop_err,
  input  logic                     rx_done,
  output logic [7:0]               m_data,
  output logic [1:0]               m_err,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic [CNT_W-1:0]         parity_cnt,
  output logic [CNT_W-1:0]         stop_cnt,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic               rx_done_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [9:0]         mem_q [DEPTH];
  logic [9:0]         mem_d [DEPTH];
  logic [7:0]         m_data_q, m_data_d;
  logic [1:0]         m_err_q, m_err_d;
  logic               m_valid_q, m_valid_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   parity_cnt_q, parity_cnt_d;
  logic [CNT_W-1:0]   stop_cnt_q, stop_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               cap, err, full, pop, push;
  logic [9:0]         entry, head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state: flush beats capture and pop; the head register is rebuilt from the post-edge view.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    m_data_d     = m_data_q;
    m_err_d      = m_err_q;
    m_valid_d    = m_valid_q;
    overrun_d    = overrun_q & ~ovr_clr;
    parity_cnt_d = parity_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    push         = 1'b0;
    head         = '0;

    cap   = rx_done & ~rx_done_q;
    err   = rx_parity_err | rx_stop_err;
    full  = (count_q == CW'(DEPTH));
    pop   = m_valid_q & m_ready;
    entry = {rx_stop_err, rx_parity_err, rx_data};

    if (flush) begin
      state_d   = S_FLUSH;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      m_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (rx_en)  state_d = S_RUN;
        S_RUN:   if (!rx_en) state_d = S_IDLE;
        S_FLUSH: state_d = rx_en ? S_RUN : S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (state_q == S_RUN && rx_en && cap) begin
        if (rx_parity_err) parity_cnt_d = sat_inc(parity_cnt_q);
        if (rx_stop_err)   stop_cnt_d   = sat_inc(stop_cnt_q);
        if (!(DROP_ERR && err)) begin
          if (!full || pop) begin
            push        = 1'b1;
            frame_cnt_d = sat_inc(frame_cnt_q);
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      if (push) begin
        mem_d[wr_ptr_q] = entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      // A write landing on the new head slot bypasses the array so FWFT holds.
      if (count_d != '0) begin
        head      = (push && (wr_ptr_q == rd_ptr_d)) ? entry : mem_q[rd_ptr_d];
        m_valid_d = 1'b1;
        m_data_d  = head[7:0];
        m_err_d   = head[9:8];
      end else begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      state_q      <= S_IDLE;
      rx_done_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      m_data_q     <= '0;
      m_err_q      <= '0;
      m_valid_q    <= 1'b0;
      overrun_q    <= 1'b0;
      parity_cnt_q <= '0;
      stop_cnt_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rx_done_q    <= rx_done;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      m_data_q     <= m_data_d;
      m_err_q      <= m_err_d;
      m_valid_q    <= m_valid_d;
      overrun_q    <= overrun_d;
      parity_cnt_q <= parity_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_err      = m_err_q;
  assign m_valid    = m_valid_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign parity_cnt = parity_cnt_q;
  assign stop_cnt   = stop_cnt_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a keep-errors and a drop-errors instance share stimulus;
// a queue model predicts every popped entry, occupancy, overrun and counter values.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst, rx_en, flush, rx_parity_err, rx_stop_err, rx_done, m_ready, ovr_clr;
  logic [7:0] rx_data;

  logic [7:0] m_data0, m_data1;
  logic [1:0] m_err0, m_err1;
  logic       m_valid0, m_valid1, overrun0, overrun1;
  logic [3:0] fifo_count0, fifo_count1;
  logic [7:0] parity_cnt0, parity_cnt1, stop_cnt0, stop_cnt1, frame_cnt0, frame_cnt1;

  uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_ERR(1'b0), .CNT_W(8)) u_keep (
    .clk(clk), .rst(rst), .rx_en(rx_en), .flush(flush), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_stop_err(rx_stop_err), .rx_done(rx_done),
    .m_data(m_data0), .m_err(m_err0), .m_valid(m_valid0), .m_ready(m_ready),
    .fifo_count(fifo_count0), .overrun(overrun0), .ovr_clr(ovr_clr),
    .parity_cnt(parity_cnt0), .stop_cnt(stop_cnt0), .frame_cnt(frame_cnt0));

  uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_ERR(1'b1), .CNT_W(8)) u_drop (
    .clk(clk), .rst(rst), .rx_en(rx_en), .flush(flush), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_stop_err(rx_stop_err), .rx_done(rx_done),
    .m_data(m_data1), .m_err(m_err1), .m_valid(m_valid1), .m_ready(m_ready),
    .fifo_count(fifo_count1), .overrun(overrun1), .ovr_clr(ovr_clr),
    .parity_cnt(parity_cnt1), .stop_cnt(stop_cnt1), .frame_cnt(frame_cnt1));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pops0 = 0, pops1 = 0;

  // Model state
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int pc = 0, sc = 0, fc0 = 0, fc1 = 0;
  bit ovr0 = 1'b0, ovr1 = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       p;
    logic       s;
    logic [1:0] exp_err;
    logic       exp_keep;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_clear();
    q0.delete(); q1.delete();
    pc = 0; sc = 0; fc0 = 0; fc1 = 0; ovr0 = 1'b0; ovr1 = 1'b0;
  endtask

  // Called when a rising rx_done is driven; predicts the effect of the coming edge.
  task automatic model_cap(input logic [7:0] d, input logic p, input logic s);
    bit pop0, pop1;
    pop0 = m_ready && (q0.size() > 0);
    pop1 = m_ready && (q1.size() > 0);
    if (p) pc = sat(pc);
    if (s) sc = sat(sc);
    if (q0.size() < DEPTH || pop0) begin q0.push_back({s, p, d}); fc0 = sat(fc0); end
    else ovr0 = 1'b1;
    if (!(p | s)) begin
      if (q1.size() < DEPTH || pop1) begin q1.push_back({s, p, d}); fc1 = sat(fc1); end
      else ovr1 = 1'b1;
    end
  endtask

  // Scoreboard: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (m_valid0 && m_ready) begin
        pops0++;
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pop_keep: got %0h expected no entry", {m_err0, m_data0});
        end else chk("pop_keep", 32'({m_err0, m_data0}), 32'(q0.pop_front()));
      end
      if (m_valid1 && m_ready) begin
        pops1++;
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pop_drop: got %0h expected no entry", {m_err1, m_data1});
        end else chk("pop_drop", 32'({m_err1, m_data1}), 32'(q1.pop_front()));
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_count_keep"}, 32'(fifo_count0), 32'(q0.size()));
    chk({tag, "_count_drop"}, 32'(fifo_count1), 32'(q1.size()));
    chk({tag, "_ovr_keep"},   32'(overrun0),    32'(ovr0));
    chk({tag, "_ovr_drop"},   32'(overrun1),    32'(ovr1));
    chk({tag, "_par_keep"},   32'(parity_cnt0), 32'(pc));
    chk({tag, "_par_drop"},   32'(parity_cnt1), 32'(pc));
    chk({tag, "_stop_keep"},  32'(stop_cnt0),   32'(sc));
    chk({tag, "_stop_drop"},  32'(stop_cnt1),   32'(sc));
    chk({tag, "_frm_keep"},   32'(frame_cnt0),  32'(fc0));
    chk({tag, "_frm_drop"},   32'(frame_cnt1),  32'(fc1));
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic s, input int hold,
                      input logic rdy);
    @(posedge clk); #1;
    m_ready = rdy; rx_data = d; rx_parity_err = p; rx_stop_err = s;
    model_cap(d, p, s);
    rx_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && n < 64) begin
      @(posedge clk);
      n++;
    end
    #1;
    m_ready = 1'b0;
    if (n >= 64) begin
      n_tests++; n_fail++;
      $display("FAIL %s_drain_timeout: got %0d entries left expected 0", tag, q0.size() + q1.size());
    end
    check_state(tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{data: 8'h11, p: 1'b1, s: 1'b0, exp_err: 2'b01, exp_keep: 1'b0};
    vecs[1] = '{data: 8'h22, p: 1'b0, s: 1'b0, exp_err: 2'b00, exp_keep: 1'b1};
    vecs[2] = '{data: 8'h33, p: 1'b1, s: 1'b1, exp_err: 2'b11, exp_keep: 1'b0};

    rst = 1'b1; rx_en = 1'b0; flush = 1'b0; rx_data = '0; rx_parity_err = 1'b0;
    rx_stop_err = 1'b0; rx_done = 1'b0; m_ready = 1'b0; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid0), 0);
    chk("rst_data",  32'(m_data0), 0);
    check_state("rst");
    rst = 1'b0; rx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: long rx_done gives one frame; m_valid appears one cycle after the capture edge
    rx_data = 8'hA5; rx_parity_err = 1'b0; rx_stop_err = 1'b0;
    model_cap(8'hA5, 1'b0, 1'b0);
    rx_done = 1'b1;
    chk("t1_valid_pre", 32'(m_valid0), 0);
    @(posedge clk); #1;
    chk("t1_valid", 32'(m_valid0), 1);
    chk("t1_data",  32'(m_data0), 32'h A5);
    chk("t1_err",   32'(m_err0), 0);
    repeat (4) @(posedge clk);
    #1;
    rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_one_entry", 32'(fifo_count0), 1);
    check_state("t1");
    drain("t1");

    // 2: overflow past DEPTH, ordered drain, overrun clear
    for (int i = 0; i < 9; i++) send(8'(i), 1'b0, 1'b0, 1, 1'b0);
    chk("t2_full", 32'(fifo_count0), 8);
    chk("t2_ovr",  32'(overrun0), 1);
    check_state("t2");
    drain("t2");
    @(posedge clk); #1;
    ovr_clr = 1'b1; ovr0 = 1'b0; ovr1 = 1'b0;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("t2_ovr_clr", 32'(overrun0), 0);
    check_state("t2c");

    // 3: error policy, table driven
    do_reset();
    pops0 = 0; pops1 = 0;
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].data, vecs[i].p, vecs[i].s, 1, 1'b0);
      chk("t3_keep_data", 32'(m_data0), 32'(vecs[i].data));
      chk("t3_keep_err",  32'(m_err0), 32'(vecs[i].exp_err));
      chk("t3_drop_valid", 32'(m_valid1), 32'(vecs[i].exp_keep));
      drain("t3");
    end
    chk("t3_pops_keep", 32'(pops0), 3);
    chk("t3_pops_drop", 32'(pops1), 1);
    chk("t3_par", 32'(parity_cnt1), 2);
    chk("t3_stop", 32'(stop_cnt1), 1);
    chk("t3_frm_drop", 32'(frame_cnt1), 1);

    // 4: push and pop on a full FIFO
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 1'b0, 1'b0, 1, 1'b0);
    send(8'h4F, 1'b0, 1'b0, 1, 1'b1);
    m_ready = 1'b0;
    chk("t4_count", 32'(fifo_count0), 8);
    chk("t4_no_ovr", 32'(overrun0), 0);
    check_state("t4");
    drain("t4");

    // 5: flush coinciding with a capture
    for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 1'b0, 1'b0, 1, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; rx_data = 8'h77; rx_parity_err = 1'b0; rx_stop_err = 1'b0; rx_done = 1'b1;
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    flush = 1'b0; rx_done = 1'b0;
    chk("t5_count", 32'(fifo_count0), 0);
    chk("t5_valid", 32'(m_valid0), 0);
    chk("t5_frm",   32'(frame_cnt0), 32'(fc0));
    repeat (2) @(posedge clk);
    #1;
    chk("t5_valid_after", 32'(m_valid0), 0);
    check_state("t5");

    // 6: counter saturation, then reset mid-stream
    for (int i = 0; i < 300; i++) send(8'(i), 1'b1, 1'b0, 1, 1'b1);
    drain("t6a");
    chk("t6_par_sat", 32'(parity_cnt0), 255);
    for (int i = 0; i < 9; i++) send(8'hC0 + 8'(i), 1'b0, 1'b0, 1, 1'b0);
    check_state("t6b");
    @(posedge clk); #1;
    rst = 1'b1; rx_done = 1'b1; rx_data = 8'h99; m_ready = 1'b1;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0; rx_done = 1'b0; m_ready = 1'b0;
    chk("t6_rst_valid", 32'(m_valid0), 0);
    chk("t6_rst_data",  32'(m_data0), 0);
    chk("t6_rst_err",   32'(m_err0), 0);
    chk("t6_rst_data_drop", 32'(m_data1), 0);
    check_state("t6r");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller placed between the UART receiver and the host logic. It qualifies the receiver's frame-complete strobe and captures each byte with its parity and stop error flags. Captured bytes go into a small FIFO and are presented to the host on a valid/ready handshake. The block also enforces the error-drop policy, tracks overrun and keeps saturating error statistics.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
DROP_ERR, 0, 1 = frames with a parity or stop error are counted but not written to the FIFO
CNT_W, 8, width of each saturating statistics counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_en  input  1  1 = accept frames; 0 = ignore receiver strobes
flush  input  1  one-cycle request to empty the FIFO
rx_data  input  8  byte from the receiver
rx_parity_err  input  1  receiver parity error flag
rx_stop_err  input  1  receiver stop-bit error flag
rx_done  input  1  receiver frame-complete; may be held high for several cycles
m_data  output  8  head byte
m_err  output  2  head flags: {stop_err, parity_err}
m_valid  output  1  head entry valid
m_ready  input  1  host accepts the head entry
fifo_count  output  clog2(DEPTH)+1  current occupancy
overrun  output  1  sticky: a frame was lost because the FIFO was full
ovr_clr  input  1  clears overrun
parity_cnt  output  CNT_W  parity-error frames, saturating
stop_cnt  output  CNT_W  stop-error frames, saturating
frame_cnt  output  CNT_W  accepted frames, saturating

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset state: m_valid=0, fifo_count=0, overrun=0, all counters=0, m_data=0, m_err=0, FSM in IDLE.
- Capture strobe: cap = rx_done & ~rx_done_q, where rx_done_q is rx_done registered. One frame per rising edge, however long rx_done stays high.
- Sampling: rx_data and both error flags are sampled in the cap cycle.
- FSM states:
  - IDLE: entered on reset. Moves to RUN when rx_en=1.
  - RUN: a cap writes the FIFO. rx_en=0 returns to IDLE; FIFO contents are retained and remain readable.
  - FLUSH: entered from any state when flush=1. Lasts one cycle: write/read pointers and count go to 0, m_valid=0. Returns to RUN if rx_en=1, else IDLE. A cap during that flush cycle is discarded and not counted.
- Frame qualification (RUN, on cap):
  - err = parity_err | stop_err.
  - parity_cnt increments if parity_err; stop_cnt increments if stop_err (both may increment together).
  - If DROP_ERR=1 and err: no write, frame_cnt unchanged.
  - Otherwise, if the FIFO is not full (or a pop happens the same cycle): write {stop, parity, data} and increment frame_cnt.
  - Otherwise (full, no pop): set overrun, discard the frame, frame_cnt unchanged.
- Counters: saturate at 2^CNT_W-1 and never wrap. Cleared only by rst.
- overrun: a set in the same cycle as ovr_clr wins, so overrun stays 1.
- FIFO: first-word-fall-through.
  - Write in cycle N gives m_valid=1 and m_data valid from cycle N+1 when the FIFO was empty.
  - Pop = m_valid & m_ready. Head advances on the next edge.
  - Push and pop in the same cycle: count unchanged. Allowed when full and when holding a single entry; in the single-entry case m_valid stays 1 with the new head.
  - Pointers wrap modulo DEPTH.
- Host side:
  - m_data/m_err are stable while m_valid=1 and m_ready=0.
  - m_ready while m_valid=0 has no effect.
  - m_ready is honoured in IDLE.
- Reset mid-operation: rst overrides flush, cap and pop. All state returns to reset values on the next edge; buffered frames are lost.
- Priority: rst > flush > cap/pop.

Test Plan:
1. rst, rx_en=1, rx_done high 5 cycles with rx_data=0xA5, no errors -> exactly one entry; m_valid rises the cycle after the edge; m_data=0xA5, m_err=00, frame_cnt=1.
2. DEPTH=8, m_ready=0, send 9 clean frames 0x00..0x08 -> fifo_count=8, overrun=1 after the 9th; drain yields 0x00..0x07 in order; pulse ovr_clr -> overrun=0.
3. DROP_ERR=1, frames 0x11(parity err), 0x22(clean), 0x33(stop+parity err) -> only 0x22 read out; parity_cnt=2, stop_cnt=1, frame_cnt=1. With DROP_ERR=0 all three are read, with m_err=01, 00, 11.
4. FIFO full, m_ready=1 held, cap on the same cycle as a pop -> fifo_count stays 8, no overrun, new byte appears last.
5. Three bytes buffered, flush=1 coinciding with a cap -> fifo_count=0, m_valid=0 next cycle, the captured byte is absent, frame_cnt unchanged.
6. 300 parity-error frames with CNT_W=8 -> parity_cnt=255 and holds; assert rst mid-stream -> all outputs zero on the next edge, FSM in IDLE.
